oflow_mem_buffer_ctrl: RTL and testbench

//  Per-frame sequencer for oflow_mem_buffer_wrapper. On each frame_start it runs the history-read phase
//  (start_read, then one read_new_line per similarity-metric line request).
//  It then runs the write phase (start_write, then one ready_from_core per PE bbox pair, spaced by buffer latency).

---
 rtl/oflow_mem_buffer_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_oflow_mem_buffer_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_mem_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// oflow_mem_buffer_ctrl: per-frame history-read / bbox-write sequencer for the
// optical-flow buffer wrapper.                                       Rev 1.0
// ----------------------------------------------------------------------------
module oflow_mem_buffer_ctrl #(
  parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
  parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
  parameter int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6,
  parameter int WR_GAP_CYCLES               = 3,
  parameter int TIMEOUT_CYCLES              = 255
) (
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic                                   frame_start,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame,
  input  logic                                   line_req,
  input  logic                                   pe_pair_valid,
  input  logic                                   done_read,
  input  logic                                   done_write,
  output logic                                   start_read,
  output logic                                   start_write,
  output logic                                   read_new_line,
  output logic                                   ready_from_core,
  output logic                                   rnw_st,
  output logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   err_timeout
);

  localparam int TFN_W  = TOTAL_FRAME_NUM_WIDTH;
  localparam int NOHF_W = NUM_OF_HISTORY_FRAMES_WIDTH;
  localparam int NOBB_W = NUM_OF_BBOX_IN_FRAME_WIDTH;
  localparam int GAP_W  = (WR_GAP_CYCLES > 1) ? $clog2(WR_GAP_CYCLES) : 1;

  localparam logic [GAP_W-1:0] c_GAP_LAST  = GAP_W'(WR_GAP_CYCLES - 1);
  localparam logic [7:0]       c_WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_START     = 3'd1,
    ST_RD_RUN       = 3'd2,
    ST_WR_START     = 3'd3,
    ST_WR_WAIT_PE   = 3'd4,
    ST_WR_GAP       = 3'd5,
    ST_WR_DONE_WAIT = 3'd6,
    ST_FRAME_END    = 3'd7
  } state_t;

  state_t              r_state;
  logic [TFN_W-1:0]    r_frame_num;
  logic [NOHF_W-1:0]   r_hist_cnt;
  logic [NOHF_W-1:0]   r_nhist;
  logic [NOBB_W-1:0]   r_pairs;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [7:0]          r_wdog;
  logic                r_start_read;
  logic                r_start_write;
  logic                r_read_new_line;
  logic                r_ready_from_core;
  logic                r_rnw_st;
  logic                r_frame_done;
  logic                r_err_timeout;

  logic [NOBB_W:0]     w_nbox_plus1;
  logic [NOBB_W-1:0]   w_pairs_init;
  logic [NOHF_W:0]     w_hist_inc;
  logic [NOHF_W-1:0]   w_hist_next;

  // Two bboxes per write transaction, so an odd count still needs a final pair.
  assign w_nbox_plus1 = {1'b0, num_of_bbox_in_frame} + 1'b1;
  assign w_pairs_init = w_nbox_plus1[NOBB_W:1];

  // History depth saturates at the depth requested for the frame just finished.
  assign w_hist_inc  = {1'b0, r_hist_cnt} + 1'b1;
  assign w_hist_next = (w_hist_inc > {1'b0, r_nhist}) ? r_nhist : w_hist_inc[NOHF_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset_N) begin
      r_state           <= ST_IDLE;
      r_frame_num       <= '0;
      r_hist_cnt        <= '0;
      r_nhist           <= '0;
      r_pairs           <= '0;
      r_gap_cnt         <= '0;
      r_wdog            <= '0;
      r_start_read      <= 1'b0;
      r_start_write     <= 1'b0;
      r_read_new_line   <= 1'b0;
      r_ready_from_core <= 1'b0;
      r_rnw_st          <= 1'b1;
      r_frame_done      <= 1'b0;
      r_err_timeout     <= 1'b0;
    end else begin
      r_start_read      <= 1'b0;
      r_start_write     <= 1'b0;
      r_read_new_line   <= 1'b0;
      r_ready_from_core <= 1'b0;
      r_frame_done      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_nhist <= num_of_history_frames;
            r_pairs <= w_pairs_init;
            r_state <= (r_hist_cnt == '0) ? ST_WR_START : ST_RD_START;
          end
        end

        ST_RD_START: begin
          r_start_read <= 1'b1;
          r_rnw_st     <= 1'b1;
          r_wdog       <= '0;
          r_state      <= ST_RD_RUN;
        end

        ST_RD_RUN: begin
          // done_read takes priority; a coincident line request is dropped.
          if (done_read) begin
            r_state <= ST_WR_START;
          end else if (r_wdog == c_WDOG_LAST) begin
            r_err_timeout <= 1'b1;
            r_rnw_st      <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_read_new_line <= line_req;
            r_wdog          <= r_wdog + 8'd1;
          end
        end

        ST_WR_START: begin
          r_start_write <= 1'b1;
          r_rnw_st      <= 1'b0;
          if (r_pairs == '0) begin
            r_wdog  <= '0;
            r_state <= ST_WR_DONE_WAIT;
          end else begin
            r_state <= ST_WR_WAIT_PE;
          end
        end

        ST_WR_WAIT_PE: begin
          if (pe_pair_valid) begin
            r_ready_from_core <= 1'b1;
            r_pairs           <= r_pairs - 1'b1;
            r_gap_cnt         <= '0;
            r_state           <= ST_WR_GAP;
          end
        end

        ST_WR_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            if (r_pairs != '0) begin
              r_state <= ST_WR_WAIT_PE;
            end else begin
              r_wdog  <= '0;
              r_state <= ST_WR_DONE_WAIT;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        ST_WR_DONE_WAIT: begin
          if (done_write) begin
            r_state <= ST_FRAME_END;
          end else if (r_wdog == c_WDOG_LAST) begin
            r_err_timeout <= 1'b1;
            r_rnw_st      <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end

        ST_FRAME_END: begin
          r_frame_done <= 1'b1;
          r_frame_num  <= r_frame_num + 1'b1;
          r_hist_cnt   <= w_hist_next;
          r_rnw_st     <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign start_read      = r_start_read;
  assign start_write     = r_start_write;
  assign read_new_line   = r_read_new_line;
  assign ready_from_core = r_ready_from_core;
  assign rnw_st          = r_rnw_st;
  assign frame_num       = r_frame_num;
  assign busy            = (r_state != ST_IDLE);
  assign frame_done      = r_frame_done;
  assign err_timeout     = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_oflow_mem_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_oflow_mem_buffer_ctrl: directed self-checking bench for the frame sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_oflow_mem_buffer_ctrl;

  logic       clk;
  logic       reset_N;
  logic       frame_start;
  logic [2:0] num_of_history_frames;
  logic [5:0] num_of_bbox_in_frame;
  logic       line_req;
  logic       pe_pair_valid;
  logic       done_read;
  logic       done_write;
  logic       start_read;
  logic       start_write;
  logic       read_new_line;
  logic       ready_from_core;
  logic       rnw_st;
  logic [7:0] frame_num;
  logic       busy;
  logic       frame_done;
  logic       err_timeout;

  oflow_mem_buffer_ctrl u_dut (
    .clk                   (clk),
    .reset_N               (reset_N),
    .frame_start           (frame_start),
    .num_of_history_frames (num_of_history_frames),
    .num_of_bbox_in_frame  (num_of_bbox_in_frame),
    .line_req              (line_req),
    .pe_pair_valid         (pe_pair_valid),
    .done_read             (done_read),
    .done_write            (done_write),
    .start_read            (start_read),
    .start_write           (start_write),
    .read_new_line         (read_new_line),
    .ready_from_core       (ready_from_core),
    .rnw_st                (rnw_st),
    .frame_num             (frame_num),
    .busy                  (busy),
    .frame_done            (frame_done),
    .err_timeout           (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_rfc, n_rnl, n_srd, n_swr, n_fd;
  int last_rfc, min_gap, max_gap;
  int hist_m = 0;
  int exp_fn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_rfc = 0; n_rnl = 0; n_srd = 0; n_swr = 0; n_fd = 0;
    last_rfc = -1; min_gap = 1000; max_gap = 0;
  endtask

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (ready_from_core) begin
      if (last_rfc >= 0) begin
        if (cyc - last_rfc < min_gap) min_gap = cyc - last_rfc;
        if (cyc - last_rfc > max_gap) max_gap = cyc - last_rfc;
      end
      last_rfc = cyc;
      n_rfc++;
    end
    if (read_new_line) n_rnl++;
    if (start_read)    n_srd++;
    if (start_write)   n_swr++;
    if (frame_done)    n_fd++;
  end

  task automatic do_frame(input int nbox, input int nhist, input int lines, input bit poke_start);
    int  pairs;
    bit  exp_read;
    pairs    = (nbox + 1) / 2;
    exp_read = (hist_m != 0);
    clear_counts();
    num_of_bbox_in_frame  = 6'(nbox);
    num_of_history_frames = 3'(nhist);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_after_start", busy, 1);
    tick();
    if (exp_read) begin
      check("start_read_lat", start_read, 1);
      check("rnw_read", rnw_st, 1);
      for (int i = 0; i < lines; i++) begin
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        check("rnl_pulse", read_new_line, 1);
        tick();
        check("rnl_single", read_new_line, 0);
      end
      done_read = 1'b1;
      tick();
      done_read = 1'b0;
      tick();
    end
    check("start_write", start_write, 1);
    check("rnw_write", rnw_st, 0);
    pe_pair_valid = 1'b1;
    if (poke_start) frame_start = 1'b1;
    repeat (4 * pairs + 4) tick();
    pe_pair_valid = 1'b0;
    frame_start   = 1'b0;
    check("busy_done_wait", busy, 1);
    done_write = 1'b1;
    tick();
    done_write = 1'b0;
    tick();
    exp_fn = (exp_fn + 1) % 256;
    check("frame_done", frame_done, 1);
    check("frame_num", frame_num, exp_fn);
    check("rnw_end", rnw_st, 1);
    hist_m = (hist_m + 1 > nhist) ? nhist : hist_m + 1;
    tick();
    check("rfc_count", n_rfc, pairs);
    if (pairs >= 2) begin
      check("rfc_min_gap", min_gap, 4);
      check("rfc_max_gap", max_gap, 4);
    end
    check("rnl_count", n_rnl, lines);
    check("srd_count", n_srd, exp_read);
    check("swr_count", n_swr, 1);
    check("fd_count", n_fd, 1);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    reset_N = 1'b0; frame_start = 1'b0; line_req = 1'b0; pe_pair_valid = 1'b0;
    done_read = 1'b0; done_write = 1'b0;
    num_of_history_frames = 3'd0; num_of_bbox_in_frame = 6'd0;
    tick(); tick();
    check("rst_frame_num", frame_num, 0);
    check("rst_rnw", rnw_st, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_pulses", {start_read, start_write, read_new_line, ready_from_core, frame_done}, 0);
    reset_N = 1'b1;
    tick();

    do_frame(4, 3, 0, 1'b0);   // first frame: no history to read, 2 pairs
    do_frame(8, 3, 3, 1'b0);   // read 3 lines, 4 pairs
    do_frame(7, 3, 1, 1'b0);   // odd bbox count rounds up to 4 pairs
    do_frame(0, 3, 0, 1'b0);   // no pairs: straight to done_write wait
    do_frame(2, 3, 2, 1'b1);   // frame_start during busy is ignored

    while (exp_fn != 255) do_frame(0, 3, 0, 1'b0);
    do_frame(1, 3, 0, 1'b0);
    check("wrap_zero", frame_num, 0);
    do_frame(2, 3, 1, 1'b0);   // read phase still runs after wrap

    // Withheld done_write trips the watchdog.
    clear_counts();
    num_of_bbox_in_frame = 6'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("to_start_read", start_read, 1);
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    tick();
    check("to_start_write", start_write, 1);
    n = 0;
    while (!err_timeout && n < 400) begin
      tick();
      n++;
    end
    check("wdog_cycles", n, 255);
    check("wdog_err", err_timeout, 1);
    check("wdog_idle", busy, 0);
    check("wdog_frame_num", frame_num, exp_fn);
    tick(); tick();
    check("wdog_sticky", err_timeout, 1);
    check("wdog_no_done", n_fd, 0);

    // Reset during the read phase.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("mid_start_read", start_read, 1);
    line_req = 1'b1;
    reset_N  = 1'b0;
    tick();
    line_req = 1'b0;
    check("mid_rst_rnl", read_new_line, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_num", frame_num, 0);
    check("mid_rst_rnw", rnw_st, 1);
    check("mid_rst_err", err_timeout, 0);
    check("mid_rst_pulses", {start_read, start_write, ready_from_core, frame_done}, 0);
    reset_N = 1'b1;
    tick();
    hist_m = 0;
    exp_fn = 0;
    do_frame(3, 2, 0, 1'b0);   // history count was cleared by reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
